// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states,
// the latched request payload and lane-select helpers.
package mau_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } mau_state_e;

  // Request fields captured at accept; lane is already alignment-forced.
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              signed_ld;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wdata;
  } mau_req_t;

  // Effective byte lane: half keeps addr[1], word always uses lane 0.
  function automatic logic [1:0] eff_lane(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: eff_lane = addr_lo;
      SZ_HALF: eff_lane = {addr_lo[1], 1'b0};
      default: eff_lane = 2'b00;
    endcase
  endfunction

  // Low address bits that do not match the natural alignment of the access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: misaligned = addr_lo[0];
      SZ_WORD: misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational lane logic: load extraction with sign/zero extension and
// read-modify-write merge of a sub-word store into the old memory word.
module mau_lane_merge
  import mau_pkg::*;
(
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              is_signed,
  output logic [DATA_W-1:0] load_data_c,
  output logic [DATA_W-1:0] store_word_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte/half and extend it to a full word.
  always_comb begin
    byte_sel = rd_word[7:0];
    case (lane)
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      2'd3:    byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      SZ_BYTE: load_data_c = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_c = {{16{is_signed & half_sel[15]}}, half_sel};
      default: load_data_c = rd_word;
    endcase
  end

  // Replace only the addressed lanes of the old word with store data.
  always_comb begin
    store_word_c = rd_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd1:    store_word_c[15:8]  = wr_data[7:0];
          2'd2:    store_word_c[23:16] = wr_data[7:0];
          2'd3:    store_word_c[31:24] = wr_data[7:0];
          default: store_word_c[7:0]   = wr_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) store_word_c[31:16] = wr_data[15:0];
        else         store_word_c[15:0]  = wr_data[15:0];
      end
      default: store_word_c = wr_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed data memory with sub-word
// extract and read-modify-write. Optional macro MAU_MISALIGN_TRAP_EN turns
// misaligned half/word accesses into error responses instead of clearing
// the low address bits.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_wrEn,
  input  logic [DATA_W-1:0] mem_rd
);

  mau_state_e        state, state_nxt;
  mau_req_t          lat_req, lat_req_nxt;
  logic              req_ready_nxt, resp_valid_nxt, resp_err_nxt, mem_wren_nxt;
  logic [DATA_W-1:0] resp_rdata_nxt, mem_addr_nxt, mem_wd_nxt;
  logic              req_err_c;
  logic [DATA_W-1:0] load_data_c, store_word_c;

  mau_lane_merge u_lane_merge (
    .rd_word      (mem_rd),
    .wr_data      (lat_req.wdata),
    .size         (lat_req.size),
    .lane         (lat_req.lane),
    .is_signed    (lat_req.signed_ld),
    .load_data_c  (load_data_c),
    .store_word_c (store_word_c)
  );

  // Reject reserved size, out-of-range word index and (optionally) misalignment.
  always_comb begin
    req_err_c = (req_size == SZ_RSVD) || ({2'b00, req_addr[31:2]} >= MEM_WORDS);
`ifdef MAU_MISALIGN_TRAP_EN
    req_err_c = req_err_c || misaligned(req_size, req_addr[1:0]);
`endif
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt      = state;
    lat_req_nxt    = lat_req;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = resp_err;
    mem_addr_nxt   = mem_addr;
    mem_wd_nxt     = mem_wd;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          lat_req_nxt    = '{we: req_we, size: req_size, signed_ld: req_signed,
                             lane: eff_lane(req_size, req_addr[1:0]), wdata: req_wdata};
          resp_rdata_nxt = '0;
          resp_err_nxt   = req_err_c;
          if (req_err_c) begin
            state_nxt = ST_RESP;
          end else begin
            mem_addr_nxt = {req_addr[31:2], 2'b00};
            if (req_we && (req_size == SZ_WORD)) begin
              state_nxt  = ST_WR;
              mem_wd_nxt = req_wdata;
            end else begin
              state_nxt = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (lat_req.we) begin
          state_nxt  = ST_WR;
          mem_wd_nxt = store_word_c;
        end else begin
          state_nxt      = ST_RESP;
          resp_rdata_nxt = load_data_c;
        end
      end
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    req_ready_nxt  = (state_nxt == ST_IDLE);
    resp_valid_nxt = (state_nxt == ST_RESP);
    mem_wren_nxt   = (state_nxt == ST_WR);
  end

  // State and output registers; reset aborts any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_req    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      mem_wrEn   <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat_req    <= lat_req_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wd     <= mem_wd_nxt;
      mem_wrEn   <= mem_wren_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with an attached 256-word memory and
// an arithmetic reference model of loads, stores and error rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;
  logic        mem_wrEn;

  logic [31:0] dmem    [0:255];
  logic [31:0] ref_mem [0:255];
  int          checks = 0;
  int          errors = 0;
  int          wr_pulses = 0;

  mem_access_unit #(.MEM_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_wrEn   (mem_wrEn),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  // Attached memory: combinational read, write on posedge.
  assign mem_rd = dmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_wrEn) dmem[mem_addr[9:2]] = mem_wd;

  // Count write strobe cycles.
  always @(negedge clk) if (mem_wrEn) wr_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour: expected rdata/err/latency, updates ref_mem on stores.
  task automatic model(input bit we, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                       input bit [31:0] wd, output bit [31:0] rd, output bit err, output int lat);
    bit [31:0] idx, off, sh, old, val, mask;
    idx = a / 4;
    off = a % 4;
    err = (sz == 2'd3) || (idx >= 256);
`ifdef MAU_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && off != 0)) err = 1'b1;
`endif
    rd  = 32'd0;
    lat = 1;
    if (err) return;
    if (sz == 2'd1) off = off - (off % 2);
    else if (sz == 2'd2) off = 0;
    sh  = 8 * off;
    old = ref_mem[idx[7:0]];
    if (!we) begin
      lat = 2;
      if (sz == 2'd0) begin
        val = (old >> sh) & 32'hFF;
        if (sg && val >= 128) val = val - 32'd256;
      end else if (sz == 2'd1) begin
        val = (old >> sh) & 32'hFFFF;
        if (sg && val >= 32768) val = val - 32'd65536;
      end else begin
        val = old;
      end
      rd = val;
    end else begin
      lat  = (sz == 2'd2) ? 2 : 3;
      mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      ref_mem[idx[7:0]] = (old & ~(mask << sh)) | ((wd & mask) << sh);
    end
  endtask

  // One full transaction: accept, response latency, hold, handshake, memory effect.
  task automatic do_req(input bit we, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                        input bit [31:0] wd, input int hold,
                        output logic [31:0] got_rd, output logic got_err);
    bit [31:0] exp_rd;
    bit        exp_err;
    int        exp_lat, lat, guard, w0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    model(we, sz, sg, a, wd, exp_rd, exp_err, exp_lat);
    w0 = wr_pulses;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rdata", resp_rdata, exp_rd);
    chk("err", 32'(resp_err), 32'(exp_err));
    got_rd  = resp_rdata;
    got_err = resp_err;
    if (!exp_err) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, exp_rd);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_done", 32'(resp_valid), 32'd0);
    chk("back_idle", 32'(req_ready), 32'd1);
    chk("wr_pulses", 32'(wr_pulses - w0), (we && !exp_err) ? 32'd1 : 32'd0);
    if (!exp_err) chk("mem_word", dmem[a[9:2]], ref_mem[a[9:2]]);
  endtask

  initial begin
    logic [31:0] rd, old;
    logic        er;
    bit   [31:0] w, a;
    int          w0;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      dmem[i] = w;
      ref_mem[i] = w;
    end
    dmem[1] = 32'h8899AABB;
    ref_mem[1] = 32'h8899AABB;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_wren", 32'(mem_wrEn), 32'd0);

    // Directed cases on word[1]
    do_req(1'b0, 2'd0, 1'b1, 32'h4, 32'h0, 0, rd, er);
    chk("dir_lb_signed", rd, 32'hFFFFFFBB);
    do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 0, rd, er);
    chk("dir_lh_unsigned", rd, 32'h00008899);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0, rd, er);
    chk("dir_lw", rd, 32'h8899AABB);
    do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h11, 0, rd, er);
    chk("dir_sb_mem", dmem[1], 32'h889911BB);
    do_req(1'b1, 2'd3, 1'b0, 32'h4, 32'hFFFF_FFFF, 0, rd, er);
    chk("dir_rsvd_err", 32'(er), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h400, 32'h1234_5678, 0, rd, er);
    chk("dir_range_err", 32'(er), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 5, rd, er);
    chk("dir_hold_rd", rd, 32'h889911BB);
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 0, rd, er);
`ifdef MAU_MISALIGN_TRAP_EN
    chk("dir_misalign_err", 32'(er), 32'd1);
`else
    chk("dir_misalign_rd", rd, 32'h889911BB);
    chk("dir_misalign_err", 32'(er), 32'd0);
`endif

    // Reset during the WR cycle of a word store
    old = dmem[3];
    w0  = wr_pulses;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'hC; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_in_wr", 32'(mem_wrEn), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_wren", 32'(mem_wrEn), 32'd0);
    chk("rst_mid_addr", mem_addr, 32'd0);
    chk("rst_mid_wd", mem_wd, 32'd0);
    chk("rst_mid_rdata", resp_rdata, 32'd0);
    chk("rst_mid_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_write", dmem[3], old);
    chk("rst_no_pulse", 32'(wr_pulses - w0), 32'd0);
    chk("rst_ready_after", 32'(req_ready), 32'd1);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 1023));
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
             $urandom_range(0, 3), rd, er);
    end

    for (int i = 0; i < 256; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
